// File: rtl/bcd_seven_seg_display.sv
// Sequential double-dabble binary-to-BCD converter driving active-low seven-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module bcd_seven_seg_display #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [HEX_W-1:0] HEX_BLANK = {DIGITS{7'h7F}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic [HEX_W-1:0]   hex_q, hex_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               carry;
  logic               ovf_next;
  logic [HEX_W-1:0]   hex_enc;
  logic [3:0]         dig;
`ifdef LEADING_ZERO_BLANK_EN
  logic               leading;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One double-dabble step: add-3 correction, then shift in the next input MSB.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    {carry, shifted} = {adj, bin_q[BIN_W-1]};
    ovf_next = ovf_q | carry;
  end

  // Segment encoding of the step result, used only on the final step.
  always_comb begin
    hex_enc = HEX_BLANK;
    dig     = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    leading = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = shifted[4*k +: 4];
      if (ovf_next) begin
        hex_enc[7*k +: 7] = 7'h3F;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (leading && (dig == 4'd0) && (k != 0)) begin
          hex_enc[7*k +: 7] = 7'h7F;
        end else begin
          leading           = 1'b0;
          hex_enc[7*k +: 7] = seg7(dig);
        end
`else
        hex_enc[7*k +: 7] = seg7(dig);
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    hex_d      = hex_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(BIN_W - 1);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d     = bin_q << 1;
        scratch_d = shifted;
        ovf_d     = ovf_next;
        if (cnt_q == '0) begin
          // Results land together with the transition so they are valid during the done cycle.
          bcd_d      = shifted;
          overflow_d = ovf_next;
          hex_d      = hex_enc;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      hex_q      <= HEX_BLANK;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      hex_q      <= hex_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;
  assign bcd_out  = bcd_q;
  assign hex_out  = hex_q;

endmodule
